mips_mult_unit: RTL and testbench

Sequential shift-add multiplier with architectural HI/LO registers, implementing MIPS `mult`/`multu`/`mthi`/`mtlo` for the 8-bit datapath. Operands come straight from the register file's two read ports (rs → `opA`, rt → `opB`). `hi`/`lo` are consumed by the writeback mux for `mfhi`/`mflo`. The controller asserts `start` for one cycle and stalls on `busy`.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mult_shift_add_dp.sv | 46 ++++
 rtl/mips_mult_unit.sv | 158 +++++++++++++++
 tb/tb_mips_mult_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS 8-bit datapath: HI/LO width and the
// multiplier controller state encoding.
package mips_pkg;

  // Width of the architectural HI/LO registers; the writeback mux uses it too.
  localparam int MIPS_XLEN = 8;

  // Iteration counter width for the shift-add multiplier.
  localparam int MULT_CNT_W = $clog2(MIPS_XLEN);

  // Multiplier controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: holds the partial product {P_hi, P_lo} and the latched
// multiplicand magnitude. One add-then-shift iteration per step strobe.
module mult_shift_add_dp #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] a_mag,
  input  logic [N-1:0] b_mag,
  output logic [N-1:0] p_hi,
  output logic [N-1:0] p_lo
);

  logic [N-1:0] a_reg;
  logic [N:0]   addend;
  logic [N:0]   sum;

  // Conditional add of the multiplicand into P_hi, kept at N+1 bits so the
  // carry shifts into the top of P_hi instead of being lost.
  always_comb begin
    addend = '0;
    if (p_lo[0]) begin
      addend = {1'b0, a_reg};
    end
    sum = {1'b0, p_hi} + addend;
  end

  // Partial-product register: load seeds {0, |B|}, step shifts {c, P_hi, P_lo} right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else if (load) begin
      a_reg <= a_mag;
      p_hi  <= '0;
      p_lo  <= b_mag;
    end else if (step) begin
      p_hi  <= sum[N:1];
      p_lo  <= {sum[0], p_lo[N-1:1]};
    end
  end

endmodule

// File: rtl/mips_mult_unit.sv
// MIPS mult/multu/mthi/mtlo unit: sequential shift-add multiplier feeding the
// architectural HI/LO registers. HI/LO only change on mthi/mtlo in IDLE or on
// the final writeback, so partial products are never visible.
//
// Handshake: start is a single-cycle request honoured only while busy is low
// (state IDLE); requests while busy are dropped, not queued. done pulses for
// one cycle with busy low, in which hi/lo hold the new product and a new start
// may already be issued.
module mips_mult_unit
  import mips_pkg::*;
#(
  parameter int N = MIPS_XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] opA,
  input  logic [N-1:0] opB,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mult_state_t   state;
  mult_state_t   state_next;
  logic [CW-1:0] cnt;
  logic          neg;
  logic          load;
  logic          step;
  logic          wb;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  p_hi;
  logic [N-1:0]  p_lo;
  logic [2*N-1:0] prod_fixed;

  // Two's-complement magnitude for signed operands; 0x80 maps to itself and
  // is then treated as an unsigned 128, which still yields the right product.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic sgn);
    if (sgn && x[N-1]) begin
      return ~x + N'(1);
    end
    return x;
  endfunction

  assign a_mag = magnitude(opA, is_signed);
  assign b_mag = magnitude(opB, is_signed);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    wb         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = WB;
        end
      end
      WB: begin
        wb         = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Iteration counter and product sign, captured with start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      neg <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      neg <= is_signed & (opA[N-1] ^ opB[N-1]);
    end else if (step) begin
      cnt <= cnt + CW'(1);
    end
  end

  mult_shift_add_dp #(
    .N(N)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .p_hi  (p_hi),
    .p_lo  (p_lo)
  );

  // Sign fix-up over the full 2N-bit product.
  always_comb begin
    prod_fixed = {p_hi, p_lo};
    if (neg) begin
      prod_fixed = ~{p_hi, p_lo} + (2*N)'(1);
    end
  end

  // HI/LO registers: mthi/mtlo only in IDLE, product load in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (wb) begin
      hi <= prod_fixed[2*N-1:N];
      lo <= prod_fixed[N-1:0];
    end else if (state == IDLE) begin
      if (hi_we) begin
        hi <= wdata;
      end
      if (lo_we) begin
        lo <= wdata;
      end
    end
  end

  // One-cycle completion pulse following the writeback edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= wb;
    end
  end

endmodule

// File: tb/tb_mips_mult_unit.sv
// Directed bench for mips_mult_unit with hand-computed expected products.
module tb_mips_mult_unit;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [N-1:0] opA;
  logic [N-1:0] opB;
  logic         hi_we;
  logic         lo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int n_checks;
  int n_errors;

  mips_mult_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .opA       (opA),
    .opB       (opB),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply from the current (idle) cycle and return in the done cycle.
  // Checks latency, that hi/lo hold during the run, and the product.
  task automatic run_mult(input string tag, input logic sgn, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_prod);
    logic [7:0] hold_hi;
    logic [7:0] hold_lo;
    int cycles;
    start = 1'b1; is_signed = sgn; opA = a; opB = b;
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    hold_hi = hi;
    hold_lo = lo;
    cycles = 0;
    while (busy && cycles < 20) begin
      tick();
      cycles++;
      if (cycles == 4) begin
        check({tag, "_hold"}, {hold_hi, hold_lo}, {hi, lo});
      end
    end
    check({tag, "_latency"}, cycles, 9);
    check({tag, "_done"}, done, 1);
    check({tag, "_prod"}, {hi, lo}, exp_prod);
  endtask

  initial begin
    int cycles;
    int dones;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; opA = '0; opB = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_state", {busy, done, hi, lo}, 0);
    tick();

    // Products.
    run_mult("multu_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    tick();
    check("done_one_cycle", done, 0);
    run_mult("mult_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
    tick();
    run_mult("mult_ff_02", 1'b1, 8'hFF, 8'h02, 16'hFFFE);
    tick();
    run_mult("mult_00_85", 1'b1, 8'h00, 8'h85, 16'h0000);
    tick();
    run_mult("mult_85_03", 1'b1, 8'h85, 8'h03, 16'hFE8F);
    tick();
    run_mult("multu_85_03", 1'b0, 8'h85, 8'h03, 16'h018F);
    tick();

    // mthi / mtlo in IDLE.
    hi_we = 1'b1; wdata = 8'h5A;
    tick();
    hi_we = 1'b0;
    check("mthi", hi, 8'h5A);
    check("mthi_busy", busy, 0);
    lo_we = 1'b1; wdata = 8'hA5;
    tick();
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, 16'h5AA5);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 8'h3C;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, 16'h3C3C);

    // Second start during RUN is dropped.
    start = 1'b1; is_signed = 1'b0; opA = 8'h03; opB = 8'h04;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; opA = 8'h05; opB = 8'h05;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      tick();
      cycles++;
    end
    check("ign_start_done", done, 1);
    check("ign_start_prod", {hi, lo}, 16'h000C);
    dones = 0;
    repeat (12) begin
      tick();
      if (done || busy) dones++;
    end
    check("ign_start_single", dones, 0);

    // mthi during RUN is dropped.
    hi_we = 1'b1; wdata = 8'h33;
    tick();
    hi_we = 1'b0;
    start = 1'b1; opA = 8'h03; opB = 8'h04;
    tick();
    start = 1'b0;
    repeat (3) tick();
    hi_we = 1'b1; wdata = 8'hAA;
    tick();
    hi_we = 1'b0;
    check("ign_mthi_run", hi, 8'h33);
    cycles = 0;
    while (busy && cycles < 20) begin
      tick();
      cycles++;
    end
    check("ign_mthi_prod", {done, hi, lo}, {1'b1, 16'h000C});
    tick();

    // mthi together with start lands, then the product overwrites it.
    hi_we = 1'b1; wdata = 8'h77;
    start = 1'b1; opA = 8'h02; opB = 8'h02;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("mthi_with_start", hi, 8'h77);
    cycles = 0;
    while (busy && cycles < 20) begin
      tick();
      cycles++;
    end
    check("mthi_with_start_prod", {hi, lo}, 16'h0004);
    tick();

    // Asynchronous reset mid-run.
    start = 1'b1; opA = 8'h10; opB = 8'h10;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_run", {busy, done, hi, lo}, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_recover_idle", busy, 0);
    run_mult("after_rst", 1'b0, 8'h02, 8'h03, 16'h0006);

    // Back-to-back: new start issued in the done cycle.
    tick();
    run_mult("b2b_first", 1'b0, 8'h05, 8'h05, 16'h0019);
    run_mult("b2b_second", 1'b0, 8'h07, 8'h06, 16'h002A);
    tick();
    check("b2b_idle", {busy, done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
